// File: rtl/serial_paralelo_rx.sv
// Serial-to-parallel lane receiver: comma hunt, byte alignment and payload recovery.
// Optional loss-of-sync detection is compiled in with `define SYNC_LOSS_EN.
module serial_paralelo_rx #(
  parameter logic [7:0]  COMMA      = 8'hBC,
  parameter int unsigned SYNC_COUNT = 4
) (
  input  logic       clk_32f,
  input  logic       reset,
  input  logic       data_in,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       active
);

  localparam int unsigned CW = $clog2(SYNC_COUNT + 1);

  typedef enum logic [1:0] {SEARCH, ALIGN, SYNCED} state_e;

  state_e        state_q, state_d;
  logic [7:0]    sr_q, sr_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [CW-1:0] comma_cnt_q, comma_cnt_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          active_q, active_d;
  logic          boundary_c;
  logic          is_comma_c;
`ifdef SYNC_LOSS_EN
  logic [5:0]    miss_q, miss_d;
`endif

  // The window under evaluation is the registered shift register, so every
  // decision lands one edge after the last bit of the byte entered sr.
  assign boundary_c = (bit_cnt_q == 3'd7);
  assign is_comma_c = (sr_q == COMMA);

  always_comb begin
    state_d     = state_q;
    sr_d        = {sr_q[6:0], data_in};
    bit_cnt_d   = bit_cnt_q + 3'd1;
    comma_cnt_d = comma_cnt_q;
    data_d      = data_q;
    valid_d     = valid_q;
`ifdef SYNC_LOSS_EN
    miss_d      = miss_q;
`endif
    case (state_q)
      SEARCH: begin
        if (is_comma_c) begin
          bit_cnt_d   = 3'd0;
          comma_cnt_d = CW'(1);
          state_d     = (SYNC_COUNT <= 1) ? SYNCED : ALIGN;
        end
      end
      ALIGN: begin
        if (boundary_c) begin
          if (is_comma_c) begin
            if (32'(comma_cnt_q) + 32'd1 >= SYNC_COUNT) begin
              comma_cnt_d = CW'(SYNC_COUNT);
              state_d     = SYNCED;
            end else begin
              comma_cnt_d = comma_cnt_q + CW'(1);
            end
          end else begin
            comma_cnt_d = '0;
            state_d     = SEARCH;
          end
        end
      end
      SYNCED: begin
        if (boundary_c) begin
          data_d  = sr_q;
          valid_d = !is_comma_c;
`ifdef SYNC_LOSS_EN
          if (is_comma_c) begin
            miss_d = 6'd0;
          end else if (miss_q == 6'd63) begin
            miss_d      = 6'd0;
            comma_cnt_d = '0;
            state_d     = SEARCH;
          end else begin
            miss_d = miss_q + 6'd1;
          end
`endif
        end
      end
      default: state_d = SEARCH;
    endcase
    // Outputs are only meaningful while synchronised.
    if (state_d != SYNCED) begin
      data_d  = 8'h00;
      valid_d = 1'b0;
    end
    active_d = (state_d == SYNCED);
  end

  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      state_q     <= SEARCH;
      sr_q        <= 8'h00;
      bit_cnt_q   <= 3'd0;
      comma_cnt_q <= '0;
      data_q      <= 8'h00;
      valid_q     <= 1'b0;
      active_q    <= 1'b0;
`ifdef SYNC_LOSS_EN
      miss_q      <= 6'd0;
`endif
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      bit_cnt_q   <= bit_cnt_d;
      comma_cnt_q <= comma_cnt_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      active_q    <= active_d;
`ifdef SYNC_LOSS_EN
      miss_q      <= miss_d;
`endif
    end
  end

  assign data_out  = data_q;
  assign valid_out = valid_q;
  assign active    = active_q;

endmodule

// File: doc/serial_paralelo_rx.md
SERIAL_PARALELO_RX -- requirements
Module: serial_paralelo_rx

Interface
REQ-001 Parameter COMMA, default 8'hBC, the alignment/idle symbol.
REQ-002 Parameter SYNC_COUNT, default 4, the number of consecutive aligned commas required to declare sync.
REQ-003 clk_32f  input  1  serial bit clock; the only clock in the block.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 data_in  input  1  serial bit stream from the lane's parallel-to-serial transmitter; MSB first; one bit per clk_32f rising edge.
REQ-006 data_out  output  8  recovered byte, registered.
REQ-007 valid_out  output  1  data_out carries a payload byte, registered.
REQ-008 active  output  1  receiver is byte-aligned and synchronised, registered.

Function
REQ-009 Shift register sr SHALL update every clock edge as sr <= {sr[6:0], data_in}; the window W is the value of sr after the shift.
REQ-010 The FSM SHALL have exactly these states: SEARCH, ALIGN and SYNCED; SEARCH is the reset state.
REQ-011 SEARCH: W SHALL be compared against COMMA on every edge (any bit offset); on a match, the 3-bit bit counter SHALL clear to 0, the comma count SHALL be set to 1, and the FSM SHALL enter ALIGN.
REQ-012 A byte boundary SHALL occur every 8th edge after the boundary is set, when the bit counter wraps from 7 to 0; the counter wraps modulo 8.
REQ-013 ALIGN, on a boundary: if W == COMMA, the comma count SHALL increment; on reaching SYNC_COUNT, the FSM SHALL enter SYNCED.
REQ-014 ALIGN, on a boundary: if W != COMMA, the comma count SHALL clear and the FSM SHALL return to SEARCH; the same edge SHALL NOT be re-evaluated as a new SEARCH match.
REQ-015 SYNCED, on each boundary: data_out <= W and valid_out <= (W != COMMA); both SHALL hold for the 8 clocks until the next boundary.
REQ-016 Latency: data_out and valid_out SHALL update exactly 1 clk_32f edge after the edge on which the byte's last bit entered sr.
REQ-017 The comma that completes SYNC_COUNT SHALL NOT produce output; the first SYNCED output SHALL be the following byte.
REQ-018 active SHALL be 1 exactly while in SYNCED, asserting on the same edge as the FSM enters SYNCED.
REQ-019 Outside SYNCED: data_out SHALL be 8'h00 and valid_out SHALL be 0.
REQ-020 The comma count SHALL saturate at SYNC_COUNT and SHALL NOT wrap.

Reset
REQ-021 reset low SHALL immediately force: sr=0, bit counter=0, comma count=0, FSM=SEARCH, data_out=8'h00, valid_out=0, active=0.
REQ-022 Reset asserted mid-byte or mid-ALIGN SHALL discard all partial alignment; after release, hunting SHALL restart from SEARCH with an empty window.
REQ-023 The first edge after reset release SHALL shift in data_in normally.

Configuration
REQ-024 The macro SYNC_LOSS_EN SHALL control loss-of-sync detection.
REQ-025 With SYNC_LOSS_EN defined: in SYNCED, a 6-bit counter SHALL count consecutive boundaries without a comma; on the 64th such boundary, the FSM SHALL go to SEARCH, active SHALL drop, and valid_out SHALL be 0 on the next edge.
REQ-026 With SYNC_LOSS_EN defined: any comma boundary SHALL clear that 6-bit counter.
REQ-027 Without SYNC_LOSS_EN: SYNCED SHALL be left only by reset, and the 6-bit counter logic SHALL be absent.

Verification
REQ-028 Four 8'hBC bytes at offset 0, then 8'hFF -> active rises at the 4th BC boundary; data_out=8'hFF, valid_out=1 one edge after the FF byte's last bit.
REQ-029 Stream with 3 garbage bits, then 4x BC, then AA, 99 -> alignment at offset 3; outputs AA then 99, each held 8 clocks.
REQ-030 BC, BC, 8'h12, BC, BC, BC, BC -> return to SEARCH after the 12 byte; sync declared only after 4 new consecutive BCs; no output before that.
REQ-031 In SYNCED, sequence 77, BC, 88 -> valid_out 1, 0, 1 with data_out 77, BC, 88.
REQ-032 Reset pulled low 5 bits into the 3rd BC -> all outputs 0 immediately; a fresh 4x BC sequence is required to re-sync.
REQ-033 SYNC_LOSS_EN defined, 64 non-comma bytes in SYNCED -> active=0 after the 64th boundary; with 63 non-comma bytes then BC, active stays 1; without the macro, 100 non-comma bytes leave active=1.
